// File: rtl/chirp_seq_pkg.sv
// Shared types and default sizes for the chirp capture sequencer.
package chirp_seq_pkg;

  localparam int CNT_W_DEFAULT       = 32;
  localparam int IDX_W_DEFAULT       = 16;
  localparam int TIMEOUT_CYC_DEFAULT = 65536;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_READY,
    PRE,
    CHIRP,
    POST,
    GAP,
    DONE
  } seq_state_e;

endpackage

// File: rtl/chirp_capture_sequencer_if.sv
// DDS control/handshake bundle between the sequencer (master) and the chirp DDS (slave).
interface chirp_capture_sequencer_if;

  // chirp_init is a one-cycle request. The DDS answers with chirp_ready (a level,
  // sampled every cycle while waiting) and later chirp_done (a one-cycle pulse).
  // chirp_enable is held from pre-roll expiry until the cycle after chirp_done.
  logic chirp_init;
  logic chirp_enable;
  logic chirp_ready;
  logic chirp_done;
  logic chirp_active;

  modport master (
    output chirp_init,
    output chirp_enable,
    input  chirp_ready,
    input  chirp_done,
    input  chirp_active
  );

  modport slave (
    input  chirp_init,
    input  chirp_enable,
    output chirp_ready,
    output chirp_done,
    output chirp_active
  );

endinterface

// File: rtl/seq_interval_timer.sv
// Loadable saturating down-counter; a zero-length load still takes one cycle.
module seq_interval_timer #(
  parameter int W = 32
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expire
);

  logic [W-1:0] count;

  // A load of N gives N cycles before expire; a load of 0 behaves like 1.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (load) begin
      count <= (len == '0) ? '0 : len - W'(1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/chirp_capture_sequencer.sv
// Chirp DDS / ADC capture pulse sequencer for the 245.76 MHz DDS/ADC domain.
// Optional WAIT_READY/CHIRP watchdog: define CHIRP_SEQ_TIMEOUT_EN.
module chirp_capture_sequencer
  import chirp_seq_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int IDX_W       = IDX_W_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      start,
  input  logic                      abort,
  input  logic [IDX_W-1:0]          num_chirps,
  input  logic [CNT_W-1:0]          prf_period,
  input  logic [CNT_W-1:0]          adc_pre_delay,
  input  logic [CNT_W-1:0]          adc_post_hold,
  chirp_capture_sequencer_if.master dds,
  output logic                      adc_enable,
  output logic                      busy,
  output logic [IDX_W-1:0]          chirp_index,
  output logic                      burst_done,
  output logic                      aborted,
  output logic                      prf_overrun,
  output logic                      err_timeout,
  output seq_state_e                state_dbg
);

  seq_state_e       state;
  logic             chirp_init_q;
  logic             chirp_enable_q;
  logic [IDX_W-1:0] num_q;
  logic [CNT_W-1:0] prf_q;
  logic [CNT_W-1:0] pre_q;
  logic [CNT_W-1:0] post_q;

  logic             active;
  logic             wd_trip;
  logic             stop_req;
  logic             pre_entry;
  logic             post_entry;
  logic             int_load;
  logic [CNT_W-1:0] int_len;
  logic             int_expire;
  logic             prf_expire;

  // chirp_active is reported by the DDS for status only and never gates the sequence.
  logic unused_active;
  assign unused_active = dds.chirp_active;

  assign active     = (state != IDLE) && (state != DONE);
  assign stop_req   = active && (abort || wd_trip);
  assign pre_entry  = (state == WAIT_READY) && dds.chirp_ready && !stop_req;
  assign post_entry = (state == CHIRP) && dds.chirp_done && !stop_req;
  assign int_load   = pre_entry || post_entry;
  assign int_len    = pre_entry ? pre_q : post_q;

`ifdef CHIRP_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_window;

  assign wd_window = (state == WAIT_READY) || (state == CHIRP);

  // WAIT_READY and CHIRP are never adjacent, so clearing outside them restarts the count.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_cnt <= '0;
    end else if (wd_window) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_trip = wd_window && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYC);
  assign wd_trip        = 1'b0;
`endif

  // Shared by the PRE and POST windows; reloaded on entry to each.
  seq_interval_timer #(.W(CNT_W)) u_interval (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (int_load),
    .len     (int_len),
    .expire  (int_expire)
  );

  // Pulse-repetition counter, started at each pre-roll.
  seq_interval_timer #(.W(CNT_W)) u_prf (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (pre_entry),
    .len     (prf_q),
    .expire  (prf_expire)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      chirp_init_q   <= 1'b0;
      chirp_enable_q <= 1'b0;
      adc_enable     <= 1'b0;
      burst_done     <= 1'b0;
      chirp_index    <= '0;
      aborted        <= 1'b0;
      prf_overrun    <= 1'b0;
      err_timeout    <= 1'b0;
      num_q          <= '0;
      prf_q          <= '0;
      pre_q          <= '0;
      post_q         <= '0;
    end else begin
      chirp_init_q <= 1'b0;
      burst_done   <= 1'b0;
      if (stop_req) begin
        state          <= DONE;
        chirp_enable_q <= 1'b0;
        adc_enable     <= 1'b0;
        burst_done     <= 1'b1;
        if (abort)   aborted     <= 1'b1;
        if (wd_trip) err_timeout <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              num_q        <= num_chirps;
              prf_q        <= prf_period;
              pre_q        <= adc_pre_delay;
              post_q       <= adc_post_hold;
              aborted      <= 1'b0;
              prf_overrun  <= 1'b0;
              err_timeout  <= 1'b0;
              chirp_index  <= '0;
              chirp_init_q <= 1'b1;
              state        <= INIT;
            end
          end
          INIT: state <= WAIT_READY;
          WAIT_READY: begin
            if (pre_entry) begin
              adc_enable <= 1'b1;
              state      <= PRE;
            end
          end
          PRE: begin
            if (int_expire) begin
              chirp_enable_q <= 1'b1;
              state          <= CHIRP;
            end
          end
          CHIRP: begin
            if (post_entry) begin
              chirp_enable_q <= 1'b0;
              // With no hold the window closes right after done, keeping fall = hold+1.
              adc_enable     <= (post_q != '0);
              state          <= POST;
            end
          end
          POST: begin
            if (int_expire) begin
              adc_enable <= 1'b0;
              if (prf_expire) prf_overrun <= 1'b1;
              state <= GAP;
            end
          end
          GAP: begin
            if (prf_expire) begin
              if ((num_q != '0) && (chirp_index == num_q - IDX_W'(1))) begin
                burst_done <= 1'b1;
                state      <= DONE;
              end else begin
                chirp_index  <= chirp_index + IDX_W'(1);
                chirp_init_q <= 1'b1;
                state        <= INIT;
              end
            end
          end
          DONE: begin
            chirp_index <= '0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign dds.chirp_init   = chirp_init_q;
  assign dds.chirp_enable = chirp_enable_q;
  assign busy             = (state != IDLE);
  assign state_dbg        = state;

endmodule

// File: doc/chirp_capture_sequencer.md
Name: chirp_capture_sequencer

Overview:
- Programmable pulse scheduler for the chirp DDS and ADC capture path.
- Runs in the 245.76 MHz DDS/ADC domain; drives the DDS `chirp_init`/`chirp_enable` and the capture `adc_enable`.
- Per chirp it runs: DDS init, ADC pre-roll, chirp, ADC post-hold, then a wait until the next pulse-repetition boundary.
- Replaces software toggling of those three controls with cycle-exact single-shot and burst sequencing.

Parameters:
- CNT_W, 32, width of all delay/period counters and config inputs
- IDX_W, 16, width of the chirp count and chirp index
- TIMEOUT_CYC, 65536, watchdog limit in cycles (used only with the optional feature)

Ports:
- aclk  in  1  sequencer clock; connect to the 245.76 MHz DDS/ADC clock
- aresetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a sequence when idle
- abort  in  1  one-cycle pulse; terminates any sequence
- num_chirps  in  IDX_W  chirps per burst; 0 = continuous
- prf_period  in  CNT_W  cycles from one chirp's pre-roll start to the next
- adc_pre_delay  in  CNT_W  cycles adc_enable leads chirp_enable
- adc_post_hold  in  CNT_W  cycles adc_enable is held after chirp_done
- chirp_ready  in  1  DDS ready
- chirp_done  in  1  DDS done pulse
- chirp_active  in  1  DDS active (status only)
- chirp_init  out  1  DDS init pulse
- chirp_enable  out  1  DDS enable level
- adc_enable  out  1  capture window level
- busy  out  1  high whenever state is not IDLE
- chirp_index  out  IDX_W  index of the current chirp
- burst_done  out  1  one-cycle pulse at end of a sequence
- aborted  out  1  sticky flag; cleared by start
- prf_overrun  out  1  sticky flag; cleared by start
- err_timeout  out  1  sticky flag; cleared by start

Behaviour:
- Reset: all outputs 0; state IDLE.
- Config latching: num_chirps, prf_period, adc_pre_delay and adc_post_hold are latched on the cycle start is accepted. Changing the inputs mid-sequence has no effect.
- Start acceptance: start is ignored unless the state is IDLE.
- States and transitions:
  - IDLE: on start, go to INIT.
  - INIT: chirp_init=1 for exactly one cycle; go to WAIT_READY.
  - WAIT_READY: hold until chirp_ready=1, then go to PRE. On PRE entry, the PRF counter loads prf_period-1.
  - PRE: adc_enable=1. Count adc_pre_delay cycles; a value of 0 means move to CHIRP on the next cycle.
  - CHIRP: adc_enable=1, chirp_enable=1. On chirp_done=1, chirp_enable=0 from the next cycle; go to POST.
  - POST: adc_enable=1 for adc_post_hold cycles, then adc_enable=0; go to GAP.
  - GAP: wait for the PRF counter to expire. If chirp_index == num_chirps-1 and num_chirps != 0, go to DONE. Otherwise increment chirp_index (wrapping at 2^IDX_W) and go to INIT.
  - DONE: burst_done=1 for one cycle; chirp_index reset to 0; go to IDLE.
- PRF counter: decrements every cycle from PRE entry and saturates at 0. If it is already 0 on GAP entry, set prf_overrun and leave GAP after one cycle.
- Abort:
  - In any non-IDLE state, abort forces chirp_enable=0 and adc_enable=0 on the next cycle, sets aborted, and goes to DONE.
  - Abort while IDLE is ignored.
  - Abort and start in the same cycle: abort wins and the sequence does not start.
- Latency: start to chirp_init is 1 cycle. adc_enable falls exactly adc_post_hold+1 cycles after the chirp_done cycle, so the downstream FIFO tlast logic sees a clean falling edge.
- Glitch rule: adc_enable never toggles inside one chirp window.
- Status only: chirp_active is used for status; it must not gate any transition.
- Reset mid-sequence: outputs drop asynchronously.

Optional Feature:
- Macro: CHIRP_SEQ_TIMEOUT_EN.
- Defined: a watchdog counts cycles spent in WAIT_READY or CHIRP. When it reaches TIMEOUT_CYC it sets err_timeout, forces the outputs low and goes to DONE, with the same effect as abort but without setting aborted.
- Undefined: WAIT_READY and CHIRP wait indefinitely; err_timeout is tied to 0.

Decomposition:
- Package chirp_seq_pkg: state enumeration (IDLE, INIT, WAIT_READY, PRE, CHIRP, POST, GAP, DONE), default widths, TIMEOUT_CYC default.
- Sub-module seq_interval_timer: loadable down-counter with zero-length handling and an expire pulse. It is instantiated for the PRE/POST interval and for the PRF counter.

Test Plan:
- Single chirp: num_chirps=1, pre=4, post=8, prf=200, DDS model returns done 50 cycles after enable.
  - chirp_init at cycle 1; adc_enable rises 4 cycles before chirp_enable; adc_enable falls 9 cycles after done; one burst_done pulse.
- Burst: num_chirps=3, prf=200.
  - Three chirp_init pulses spaced by 200 cycles plus the ready latency; chirp_index steps 0,1,2; burst_done once.
- Zero delays and overrun: pre=0, post=0, prf=10, chirp length 50.
  - CHIRP entered the cycle after PRE; prf_overrun=1; next chirp starts immediately.
- Abort mid-chirp: abort on the 20th cycle of CHIRP.
  - chirp_enable=0 and adc_enable=0 one cycle later; aborted=1; burst_done pulses; busy falls.
- Simultaneous events: abort with start while idle.
  - Remains IDLE. Also: start during busy is ignored, and new num_chirps applied mid-burst has no effect.
- Timeout (macro defined, TIMEOUT_CYC=100): chirp_ready held low.
  - err_timeout=1 after 100 cycles in WAIT_READY; all outputs low; returns to IDLE.
